ring_buff_ctrl_wr: RTL
======================

# ring_buff_ctrl_wr

Write-side ring-buffer controller with speculative writes: the producer writes entries that stay invisible to the reader until committed, or are discarded by rollback. It complements the read-side replay controller. It drives addresses for an external dual-port buffer RAM and sits between a speculative producer (e.g. an issue stage that may squash) and an in-order consumer.

## Interface
- NUM_ENTRY, 16, buffer depth; power of two, ≥4; W = $clog2(NUM_ENTRY)
- AF_GAP, 2, O_AlmostFull asserts when free entries ≤ AF_GAP
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- I_We  in  1  speculative write request
- I_Commit  in  1  publish all uncommitted entries, including a write accepted this cycle
- I_Rollback  in  1  discard all uncommitted entries
- I_Re  in  1  read request
- O_WAddr  out  W  current write address
- O_RAddr  out  W  current read address
- O_Full  out  1  no free entry (committed plus uncommitted = NUM_ENTRY)
- O_AlmostFull  out  1  free entries ≤ AF_GAP
- O_Empty  out  1  no committed entry readable
- O_Num  out  W+1  committed, unread entries (0..NUM_ENTRY)
- O_NumSpec  out  W+1  uncommitted entries (0..NUM_ENTRY)
- O_Pending  out  1  FSM in SPEC state

## Operation
- Three pointers, each W+1 bits with a wrap bit: R_WPtr (speculative head), R_CPtr (commit point), R_RPtr (tail). All arithmetic is mod 2^(W+1).
- O_Num = R_CPtr − R_RPtr. O_NumSpec = R_WPtr − R_CPtr. Free = NUM_ENTRY − (R_WPtr − R_RPtr).
- Write accepted = I_We & ~O_Full. Write when full is dropped and the pointer is unchanged.
- Read accepted = I_Re & ~O_Empty. Reads never see uncommitted data. A write in the same cycle does not make an empty buffer readable.
- Commit: R_CPtr ← R_WPtr + (write accepted).
- Rollback: R_WPtr ← R_CPtr, and a write in the same cycle is discarded. If rollback and commit arrive together, rollback wins and the commit is ignored.
- A read in the same cycle as commit or rollback proceeds normally. Commit or rollback never moves R_RPtr.
- FSM (enum in package):
  - IDLE → SPEC on an accepted write without commit or rollback.
  - SPEC → IDLE on commit or rollback.
  - IDLE with write plus commit stays IDLE.
  - O_Pending = (state == SPEC). The invariant O_Pending == (O_NumSpec != 0) always holds.

## Timing
- All pointers and the FSM are registered. Flags and counts are combinational from the registers, so there is no input-to-output combinational path.
- O_WAddr and O_RAddr are valid in the cycle of the request. The RAM writes or reads at that address on the same edge.
- Pointer updates are visible one cycle after the accepting edge. Committed data is readable starting the cycle after the commit.
- Reset is asynchronous. It clears all pointers and forces IDLE.
  - Reset values: O_WAddr=0, O_RAddr=0, O_Full=0, O_AlmostFull=0, O_Empty=1, O_Num=0, O_NumSpec=0, O_Pending=0.
  - Reset mid-speculation discards everything, committed or not.
- Wrap-around is handled by the wrap bit. Full and empty are distinguished when the low W bits are equal.

## Configuration
- RING_BUFF_WR_ERR_EN adds output O_Err (1 bit, resets to 0).
  - O_Err is a sticky flag set on write-when-full, read-when-empty, or commit with rollback together.
  - Only reset clears it.
- Without the macro, the O_Err port and its logic are absent. Illegal requests are silently ignored as described above.

## Structure
- Package ring_buff_pkg holds:
  - typedef enum logic {ST_IDLE, ST_SPEC} rb_wr_state_t
  - helper function for mod-2^(W+1) pointer difference
- Sub-module ring_ptr (W+1-bit counter with increment and load) is instantiated three times, for the W, C and R pointers.

## Test plan
- Reset, then 5 writes, then commit → O_NumSpec goes 5→0, O_Num=5, O_Empty=0 the cycle after the commit.
- 3 writes plus commit, then 4 writes, then rollback → O_Num=3, O_NumSpec=0, O_WAddr=3, O_Pending=0.
- 16 writes with commit on the last → O_Full=1, O_AlmostFull=1, O_Num=16. A 17th write leaves O_WAddr=0 and sets O_Err=1 (macro on).
- Empty buffer, I_We and I_Re in the same cycle → read ignored, O_RAddr=0, O_NumSpec=1, O_Empty stays 1.
- 20 write/commit/read cycles → O_WAddr and O_RAddr wrap 15→0 correctly, with O_Num steady at 1.
- Commit and rollback together with 2 uncommitted entries → rollback wins, O_NumSpec=0, O_Num unchanged. Assert reset asynchronously mid-burst → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/ring_buff_pkg.sv
// Shared types and helpers for the speculative-write ring-buffer controller.
package ring_buff_pkg;

  typedef enum logic {ST_IDLE, ST_SPEC} rb_wr_state_t;

  localparam int unsigned PTR_CALC_W = 32;

  // Difference of two wrap-bit pointers, reduced mod 2^pw.
  function automatic logic [PTR_CALC_W-1:0] ptr_diff(
    input logic [PTR_CALC_W-1:0] a,
    input logic [PTR_CALC_W-1:0] b,
    input int unsigned           pw
  );
    logic [PTR_CALC_W-1:0] mask;
    mask = (PTR_CALC_W'(1) << pw) - PTR_CALC_W'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Wrap-bit pointer register with synchronous load (priority) and increment.
module ring_ptr #(
  parameter int unsigned PW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [PW-1:0] load_val,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)     ptr <= '0;
    else if (load) ptr <= load_val;
    else if (inc)  ptr <= ptr + PW'(1);
  end

endmodule

// File: rtl/ring_buff_ctrl_wr.sv
// Write-side ring-buffer controller: speculative writes published by commit or dropped by rollback.
// Optional sticky error output O_Err is built when RING_BUFF_WR_ERR_EN is defined.
module ring_buff_ctrl_wr
  import ring_buff_pkg::*;
#(
  parameter int unsigned NUM_ENTRY = 16,
  parameter int unsigned AF_GAP    = 2,
  localparam int unsigned W        = $clog2(NUM_ENTRY),
  localparam int unsigned PW       = W + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          I_We,
  input  logic          I_Commit,
  input  logic          I_Rollback,
  input  logic          I_Re,
  output logic [W-1:0]  O_WAddr,
  output logic [W-1:0]  O_RAddr,
  output logic          O_Full,
  output logic          O_AlmostFull,
  output logic          O_Empty,
  output logic [W:0]    O_Num,
  output logic [W:0]    O_NumSpec,
  output logic          O_Pending
`ifdef RING_BUFF_WR_ERR_EN
  ,
  output logic          O_Err
`endif
);

  logic [PW-1:0] w_ptr, c_ptr, r_ptr;
  logic [PW-1:0] used, free_cnt, num, num_spec;
  logic          full, empty, wr_acc, rd_acc;
  rb_wr_state_t  state, state_nxt;
  logic          pending;

  // Occupancy derived from the registered pointers only.
  assign num      = PW'(ptr_diff(PTR_CALC_W'(c_ptr), PTR_CALC_W'(r_ptr), PW));
  assign num_spec = PW'(ptr_diff(PTR_CALC_W'(w_ptr), PTR_CALC_W'(c_ptr), PW));
  assign used     = PW'(ptr_diff(PTR_CALC_W'(w_ptr), PTR_CALC_W'(r_ptr), PW));
  assign free_cnt = PW'(NUM_ENTRY) - used;
  assign full     = (used == PW'(NUM_ENTRY));
  assign empty    = (num == '0);

  assign wr_acc = I_We & ~full;
  assign rd_acc = I_Re & ~empty;

  ring_ptr #(.PW(PW)) u_wptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (wr_acc),
    .load     (I_Rollback),
    .load_val (c_ptr),
    .ptr      (w_ptr)
  );

  // Commit publishes up to and including a write accepted on the same edge.
  ring_ptr #(.PW(PW)) u_cptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (1'b0),
    .load     (I_Commit & ~I_Rollback),
    .load_val (w_ptr + PW'(wr_acc)),
    .ptr      (c_ptr)
  );

  ring_ptr #(.PW(PW)) u_rptr (
    .clock    (clock),
    .reset    (reset),
    .inc      (rd_acc),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (r_ptr)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pending   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_acc && !I_Commit && !I_Rollback) state_nxt = ST_SPEC;
      end
      ST_SPEC: begin
        pending = 1'b1;
        if (I_Commit || I_Rollback) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign O_WAddr      = w_ptr[W-1:0];
  assign O_RAddr      = r_ptr[W-1:0];
  assign O_Full       = full;
  assign O_AlmostFull = (free_cnt <= PW'(AF_GAP));
  assign O_Empty      = empty;
  assign O_Num        = num;
  assign O_NumSpec    = num_spec;
  assign O_Pending    = pending;

`ifdef RING_BUFF_WR_ERR_EN
  // Sticky record of any illegal request; cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      O_Err <= 1'b0;
    else if ((I_We && full) || (I_Re && empty) || (I_Commit && I_Rollback))
      O_Err <= 1'b1;
  end
`endif

endmodule
